// File: rtl/svc_rv_pkg.sv
// Shared RV SoC definitions: read-response owner tag used by the memory arbiter.
package svc_rv_pkg;

  typedef enum logic [1:0] {
    OWN_NONE   = 2'd0,
    OWN_IFETCH = 2'd1,
    OWN_DATA   = 2'd2
  } owner_e;

endpackage

// File: rtl/svc_rv_mem_arb.sv
// Single-port SRAM arbiter between instruction fetch and data load/store,
// data-priority with bounded fetch starvation and 1-cycle read latency.
module svc_rv_mem_arb
  import svc_rv_pkg::*;
#(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_valid,
  input  logic [AW-1:0]   i_addr,
  output logic            i_ready,
  output logic            i_rdata_valid,
  output logic [DW-1:0]   i_rdata,
  input  logic            d_valid,
  input  logic            d_write,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_wstrb,
  output logic            d_ready,
  output logic            d_rdata_valid,
  output logic [DW-1:0]   d_rdata,
  output logic            sram_rd_en,
  output logic [AW-1:0]   sram_rd_addr,
  input  logic [DW-1:0]   sram_rd_data,
  output logic            sram_wr_en,
  output logic [AW-1:0]   sram_wr_addr,
  output logic [DW-1:0]   sram_wr_data,
  output logic [DW/8-1:0] sram_wr_strb
);

  localparam int unsigned   CW         = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  logic [CW-1:0] starve_q, starve_d;
  owner_e        owner_q, owner_d;
  logic          grant_i, grant_d, d_rd, d_wr;

  always_comb begin
    // Fetch wins only when data is absent or fetch has waited STARVE_MAX cycles.
    grant_i = i_valid && (!d_valid || (starve_q == STARVE_LIM));
    grant_d = d_valid && !grant_i;
    d_rd    = grant_d && !d_write;
    d_wr    = grant_d && d_write;

    starve_d = starve_q;
    if (!i_valid || grant_i) begin
      starve_d = '0;
    end else if (starve_q != STARVE_LIM) begin
      starve_d = starve_q + 1'b1;
    end

    owner_d = OWN_NONE;
    if (grant_i) begin
      owner_d = OWN_IFETCH;
    end else if (d_rd) begin
      owner_d = OWN_DATA;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
      owner_q  <= OWN_NONE;
    end else begin
      starve_q <= starve_d;
      owner_q  <= owner_d;
    end
  end

  always_comb begin
    i_ready       = grant_i;
    d_ready       = grant_d;
    i_rdata_valid = (owner_q == OWN_IFETCH);
    d_rdata_valid = (owner_q == OWN_DATA);
    i_rdata       = sram_rd_data;
    d_rdata       = sram_rd_data;

    sram_rd_en    = grant_i || d_rd;
    sram_rd_addr  = '0;
    if (grant_i) begin
      sram_rd_addr = i_addr;
    end else if (d_rd) begin
      sram_rd_addr = d_addr;
    end

    sram_wr_en   = d_wr;
    sram_wr_addr = d_wr ? d_addr  : '0;
    sram_wr_data = d_wr ? d_wdata : '0;
    sram_wr_strb = d_wr ? d_wstrb : '0;
  end

endmodule

// File: tb/tb_svc_rv_mem_arb.sv
// Directed bench for svc_rv_mem_arb with a behavioural SRAM and a response scoreboard.
module tb_svc_rv_mem_arb;

  logic        clk;
  logic        rst_n;
  logic        i_valid;
  logic [31:0] i_addr;
  logic        i_ready;
  logic        i_rdata_valid;
  logic [31:0] i_rdata;
  logic        d_valid;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_ready;
  logic        d_rdata_valid;
  logic [31:0] d_rdata;
  logic        sram_rd_en;
  logic [31:0] sram_rd_addr;
  logic [31:0] sram_rd_data;
  logic        sram_wr_en;
  logic [31:0] sram_wr_addr;
  logic [31:0] sram_wr_data;
  logic [3:0]  sram_wr_strb;

  svc_rv_mem_arb #(.AW(32), .DW(32), .STARVE_MAX(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_valid      (i_valid),
    .i_addr       (i_addr),
    .i_ready      (i_ready),
    .i_rdata_valid(i_rdata_valid),
    .i_rdata      (i_rdata),
    .d_valid      (d_valid),
    .d_write      (d_write),
    .d_addr       (d_addr),
    .d_wdata      (d_wdata),
    .d_wstrb      (d_wstrb),
    .d_ready      (d_ready),
    .d_rdata_valid(d_rdata_valid),
    .d_rdata      (d_rdata),
    .sram_rd_en   (sram_rd_en),
    .sram_rd_addr (sram_rd_addr),
    .sram_rd_data (sram_rd_data),
    .sram_wr_en   (sram_wr_en),
    .sram_wr_addr (sram_wr_addr),
    .sram_wr_data (sram_wr_data),
    .sram_wr_strb (sram_wr_strb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM: one-cycle registered read, byte-strobed write.
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (sram_rd_en) sram_rd_data <= mem[sram_rd_addr[7:0]];
    if (sram_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (sram_wr_strb[b]) mem[sram_wr_addr[7:0]][8*b +: 8] <= sram_wr_data[8*b +: 8];
      end
    end
  end

  typedef struct {
    logic [1:0]  own;   // 0 none, 1 fetch, 2 data
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem [0:255];
  int          checks;
  int          errors;
  int          cnt_m;
  logic        last_i_ready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, check responses and grant outputs, predict next response.
  task automatic step(input logic iv, input logic [31:0] ia, input logic dv, input logic dw,
                      input logic [31:0] da, input logic [31:0] dwd, input logic [3:0] ds);
    exp_t e, n;
    logic gi, gd;
    i_valid = iv; i_addr = ia;
    d_valid = dv; d_write = dw; d_addr = da; d_wdata = dwd; d_wstrb = ds;
    #1;
    chk("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("i_rdata_valid", 32'(i_rdata_valid), 32'(e.own == 2'd1));
      chk("d_rdata_valid", 32'(d_rdata_valid), 32'(e.own == 2'd2));
      if (e.own == 2'd1) chk("i_rdata", i_rdata, e.data);
      if (e.own == 2'd2) chk("d_rdata", d_rdata, e.data);
    end
    gi = iv && (!dv || cnt_m == 4);
    gd = dv && !gi;
    last_i_ready = i_ready;
    chk("i_ready", 32'(i_ready), 32'(gi));
    chk("d_ready", 32'(d_ready), 32'(gd));
    chk("sram_rd_en", 32'(sram_rd_en), 32'(gi || (gd && !dw)));
    chk("sram_rd_addr", sram_rd_addr, gi ? ia : ((gd && !dw) ? da : 32'd0));
    chk("sram_wr_en", 32'(sram_wr_en), 32'(gd && dw));
    if (gd && dw) begin
      chk("sram_wr_addr", sram_wr_addr, da);
      chk("sram_wr_data", sram_wr_data, dwd);
      chk("sram_wr_strb", 32'(sram_wr_strb), 32'(ds));
    end
    n.own = 2'd0; n.data = '0;
    if (gi) begin
      n.own = 2'd1; n.data = ref_mem[ia[7:0]];
    end else if (gd && !dw) begin
      n.own = 2'd2; n.data = ref_mem[da[7:0]];
    end else if (gd) begin
      for (int b = 0; b < 4; b++) if (ds[b]) ref_mem[da[7:0]][8*b +: 8] = dwd[8*b +: 8];
    end
    exp_q.push_back(n);
    if (!iv || gi) cnt_m = 0;
    else if (cnt_m < 4) cnt_m++;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
  endtask

  task automatic after_reset();
    exp_t n;
    exp_q.delete();
    n.own = 2'd0; n.data = '0;
    exp_q.push_back(n);
    cnt_m = 0;
  endtask

  initial begin
    int first;
    checks = 0; errors = 0; cnt_m = 0; last_i_ready = 1'b0;
    for (int k = 0; k < 256; k++) begin
      mem[k] = '0; ref_mem[k] = '0;
    end
    mem[8'h00] = 32'h0000_0013; ref_mem[8'h00] = 32'h0000_0013;
    mem[8'h04] = 32'hCAFE_F00D; ref_mem[8'h04] = 32'hCAFE_F00D;
    mem[8'h10] = 32'hDEAD_BEEF; ref_mem[8'h10] = 32'hDEAD_BEEF;
    mem[8'h21] = 32'h1122_3344; ref_mem[8'h21] = 32'h1122_3344;
    sram_rd_data = '0;
    rst_n = 1'b0;
    i_valid = 1'b0; i_addr = '0;
    d_valid = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst_i_rdata_valid", 32'(i_rdata_valid), 32'd0);
    chk("rst_d_rdata_valid", 32'(d_rdata_valid), 32'd0);
    chk("rst_sram_rd_en", 32'(sram_rd_en), 32'd0);
    chk("rst_sram_wr_en", 32'(sram_wr_en), 32'd0);
    rst_n = 1'b1;
    after_reset();

    // Fetch only, granted on the first edge after reset release
    step(1'b1, 32'h10, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    idle();

    // Both valid with a data write: data wins, no response for the write
    step(1'b1, 32'h10, 1'b1, 1'b1, 32'h20, 32'h1234_5678, 4'hF);
    step(1'b1, 32'h10, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    step(1'b0, 32'd0, 1'b1, 1'b1, 32'h21, 32'hAABB_CCDD, 4'h3);
    step(1'b0, 32'd0, 1'b1, 1'b0, 32'h20, 32'd0, 4'd0);
    step(1'b0, 32'd0, 1'b1, 1'b0, 32'h21, 32'd0, 4'd0);
    idle();
    chk("partial_strobe_ref", ref_mem[8'h21], 32'h1122_CCDD);

    // Starvation: fetch wins on the 5th cycle, then data regains priority
    first = -1;
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 32'h0, 1'b1, 1'b0, 32'h4, 32'd0, 4'd0);
      if (last_i_ready && first < 0) first = k;
    end
    chk("starve_first_fetch_cycle", 32'(first), 32'd4);
    idle();

    // Alternating fetch / data reads, no bubbles
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) step(1'b1, 32'h0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      else            step(1'b0, 32'd0, 1'b1, 1'b0, 32'h4, 32'd0, 4'd0);
    end
    // read, read, write, read back to back
    step(1'b0, 32'd0, 1'b1, 1'b0, 32'h4, 32'd0, 4'd0);
    step(1'b1, 32'h10, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    step(1'b0, 32'd0, 1'b1, 1'b1, 32'h30, 32'h0BAD_CAFE, 4'hF);
    step(1'b0, 32'd0, 1'b1, 1'b0, 32'h30, 32'd0, 4'd0);
    idle();

    // Reset right after a data read grant with a partly charged starvation counter
    step(1'b1, 32'h0, 1'b1, 1'b0, 32'h4, 32'd0, 4'd0);
    step(1'b1, 32'h0, 1'b1, 1'b0, 32'h4, 32'd0, 4'd0);
    step(1'b1, 32'h0, 1'b1, 1'b0, 32'h4, 32'd0, 4'd0);
    rst_n = 1'b0;
    i_valid = 1'b0; d_valid = 1'b0;
    #1;
    chk("midrst_d_rdata_valid", 32'(d_rdata_valid), 32'd0);
    chk("midrst_i_rdata_valid", 32'(i_rdata_valid), 32'd0);
    @(negedge clk);
    chk("midrst_hold_d_rdata_valid", 32'(d_rdata_valid), 32'd0);
    rst_n = 1'b1;
    after_reset();
    first = -1;
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 32'h10, 1'b1, 1'b0, 32'h20, 32'd0, 4'd0);
      if (last_i_ready && first < 0) first = k;
    end
    chk("post_reset_starve_cycle", 32'(first), 32'd4);
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
